min_finder_seq: RTL and testbench

- Serial-input counterpart of the team's parallel min finder.
- Accepts a frame of N_NUMBER unsigned values, one per handshake, over a valid/ready stream.
- Tracks the smallest value, the second-smallest value and the index of the smallest value incrementally.
- Presents the registered result on a valid/ready result port; the next frame may be collected while the current result waits.

---
 rtl/min_finder_pkg.sv | 7 +
 rtl/min_finder_upd.sv | 48 ++++
 rtl/min_finder_seq.sv | 114 +++++++++++
 tb/tb_min_finder_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/min_finder_pkg.sv
// Shared constants and FSM state type for the serial min finder.
package min_finder_pkg;
  localparam int N_NUMBER_DEF = 10;
  localparam int N_BIT_DEF    = 4;

  typedef enum logic {COLLECT, HOLD} state_e;
endpackage

// File: rtl/min_finder_upd.sv
// Combinational compare/update cell: folds one value into the running min1/min2/index.
// MIN_FINDER_SEQ_INDEX2_EN adds tracking of the min2 source position.
module min_finder_upd #(
  parameter int N_BIT = 4,
  parameter int IDX_W = 4
) (
  input  logic [N_BIT-1:0] data_i,
  input  logic [N_BIT-1:0] run_min1_i,
  input  logic [N_BIT-1:0] run_min2_i,
  input  logic [IDX_W-1:0] run_idx_i,
`ifdef MIN_FINDER_SEQ_INDEX2_EN
  input  logic [IDX_W-1:0] run_idx2_i,
  output logic [IDX_W-1:0] next_idx2_o,
`endif
  input  logic [IDX_W-1:0] cnt_i,
  output logic [N_BIT-1:0] next_min1_o,
  output logic [N_BIT-1:0] next_min2_o,
  output logic [IDX_W-1:0] next_idx_o
);
  logic below_min1;
  logic below_min2;

  // Strict compares: a tie with min1 falls to the min2 branch, keeping the first index.
  assign below_min1 = data_i < run_min1_i;
  assign below_min2 = data_i < run_min2_i;

  always_comb begin
    next_min1_o = run_min1_i;
    next_min2_o = run_min2_i;
    next_idx_o  = run_idx_i;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
    next_idx2_o = run_idx2_i;
`endif
    if (below_min1) begin
      next_min2_o = run_min1_i;
      next_min1_o = data_i;
      next_idx_o  = cnt_i;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
      next_idx2_o = run_idx_i;
`endif
    end else if (below_min2) begin
      next_min2_o = data_i;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
      next_idx2_o = cnt_i;
`endif
    end
  end
endmodule

// File: rtl/min_finder_seq.sv
// Serial min finder: collects N_NUMBER values per frame and reports min1, min2 and min1 index.
// MIN_FINDER_SEQ_INDEX2_EN adds the index_min2_o output.
module min_finder_seq
  import min_finder_pkg::*;
#(
  parameter int N_NUMBER = N_NUMBER_DEF,
  parameter int N_BIT    = N_BIT_DEF,
  parameter int IDX_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BIT-1:0] data_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  output logic [N_BIT-1:0] min1_o,
  output logic [N_BIT-1:0] min2_o,
  output logic [IDX_W-1:0] index_min1_o,
`ifdef MIN_FINDER_SEQ_INDEX2_EN
  output logic [IDX_W-1:0] index_min2_o,
`endif
  output logic             result_valid_o,
  input  logic             result_ready_i
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NUMBER - 1);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [N_BIT-1:0] run_min1_q, run_min2_q;
  logic [IDX_W-1:0] run_idx_q;
  logic [N_BIT-1:0] run_min1_d, run_min2_d;
  logic [IDX_W-1:0] run_idx_d;
  logic [N_BIT-1:0] min1_q, min2_q;
  logic [IDX_W-1:0] idx1_q;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
  logic [IDX_W-1:0] run_idx2_q, run_idx2_d, idx2_q;
`endif

  logic is_last, accept, final_acc, take;

  assign is_last        = cnt_q == LAST_IDX;
  assign result_valid_o = state_q == HOLD;
  // Only the closing element has to wait for the previous result to be consumed.
  assign data_ready_o   = !(is_last && result_valid_o && !result_ready_i);
  assign accept         = data_valid_i && data_ready_o;
  assign final_acc      = accept && is_last;
  assign take           = result_valid_o && result_ready_i;

  assign min1_o       = min1_q;
  assign min2_o       = min2_q;
  assign index_min1_o = idx1_q;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
  assign index_min2_o = idx2_q;
`endif

  min_finder_upd #(.N_BIT(N_BIT), .IDX_W(IDX_W)) u_upd (
    .data_i      (data_i),
    .run_min1_i  (run_min1_q),
    .run_min2_i  (run_min2_q),
    .run_idx_i   (run_idx_q),
`ifdef MIN_FINDER_SEQ_INDEX2_EN
    .run_idx2_i  (run_idx2_q),
    .next_idx2_o (run_idx2_d),
`endif
    .cnt_i       (cnt_q),
    .next_min1_o (run_min1_d),
    .next_min2_o (run_min2_d),
    .next_idx_o  (run_idx_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      run_min1_q <= '1;
      run_min2_q <= '1;
      run_idx_q  <= '0;
      min1_q     <= '0;
      min2_q     <= '0;
      idx1_q     <= '0;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
      run_idx2_q <= '0;
      idx2_q     <= '0;
`endif
    end else begin
      if (final_acc) begin
        // Result takes the values including the closing element; running state restarts.
        min1_q     <= run_min1_d;
        min2_q     <= run_min2_d;
        idx1_q     <= run_idx_d;
        cnt_q      <= '0;
        run_min1_q <= '1;
        run_min2_q <= '1;
        run_idx_q  <= '0;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
        idx2_q     <= run_idx2_d;
        run_idx2_q <= '0;
`endif
      end else if (accept) begin
        cnt_q      <= cnt_q + IDX_W'(1);
        run_min1_q <= run_min1_d;
        run_min2_q <= run_min2_d;
        run_idx_q  <= run_idx_d;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
        run_idx2_q <= run_idx2_d;
`endif
      end
      case (state_q)
        COLLECT: if (final_acc) state_q <= HOLD;
        HOLD:    if (take && !final_acc) state_q <= COLLECT;
        default: state_q <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_min_finder_seq.sv
// Scoreboard bench for min_finder_seq: directed frames, backpressure, valid gaps, mid-frame reset.
module tb_min_finder_seq;
  logic       clk = 1'b0;
  logic       rst_i;
  logic [3:0] data_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [3:0] min1_o, min2_o, index_min1_o;
`ifdef MIN_FINDER_SEQ_INDEX2_EN
  logic [3:0] index_min2_o;
`endif
  logic       result_valid_o;
  logic       result_ready_i;

  always #5 clk = ~clk;

  min_finder_seq #(.N_NUMBER(10), .N_BIT(4), .IDX_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .min1_o         (min1_o),
    .min2_o         (min2_o),
    .index_min1_o   (index_min1_o),
`ifdef MIN_FINDER_SEQ_INDEX2_EN
    .index_min2_o   (index_min2_o),
`endif
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i)
  );

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] i1;
    logic [3:0] i2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Hand-computed frames and expected {min1, min2, index_min1, index_min2}.
  int frm [6][10] = '{
    '{7, 3, 9, 3, 12, 1, 5, 8, 2, 14},
    '{4, 6, 4, 9, 9, 9, 9, 9, 9, 9},
    '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15},
    '{8, 5, 11, 5, 0, 13, 2, 0, 7, 6},
    '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6},
    '{2, 15, 15, 15, 15, 15, 15, 15, 15, 3}
  };
  exp_t exp_tab [6] = '{
    '{4'd1,  4'd2,  4'd5, 4'd8},
    '{4'd4,  4'd4,  4'd0, 4'd2},
    '{4'd15, 4'd15, 4'd0, 4'd0},
    '{4'd0,  4'd0,  4'd4, 4'd7},
    '{4'd6,  4'd7,  4'd9, 4'd8},
    '{4'd2,  4'd3,  4'd0, 4'd9}
  };

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per result handshake; checks hold stability under backpressure.
  exp_t       e;
  bit         prev_hold = 1'b0;
  logic [3:0] p1, p2, pi;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && result_valid_o) begin
        chk("stable_min1", int'(min1_o), int'(p1));
        chk("stable_min2", int'(min2_o), int'(p2));
        chk("stable_idx", int'(index_min1_o), int'(pi));
      end
      if (result_valid_o && result_ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got min1=%0d, required no result", min1_o);
        end else begin
          e = sb.pop_front();
          $display("result taken: min1=%0d min2=%0d idx=%0d (want %0d %0d %0d)",
                   min1_o, min2_o, index_min1_o, e.m1, e.m2, e.i1);
          chk("min1", int'(min1_o), int'(e.m1));
          chk("min2", int'(min2_o), int'(e.m2));
          chk("index_min1", int'(index_min1_o), int'(e.i1));
`ifdef MIN_FINDER_SEQ_INDEX2_EN
          chk("index_min2", int'(index_min2_o), int'(e.i2));
`endif
        end
      end
      prev_hold = result_valid_o && !result_ready_i;
      p1 = min1_o;
      p2 = min2_o;
      pi = index_min1_o;
    end
  end

  task automatic drive(input int v, input bit gaps);
    bit done;
    int waited;
    int idle;
    idle = 0;
    if (gaps) begin
      while (idle < 4 && $urandom_range(0, 1) == 1) begin
        data_valid_i = 1'b0;
        data_i = 4'($urandom);
        @(posedge clk); #1;
        idle++;
      end
    end
    data_valid_i = 1'b1;
    data_i = v[3:0];
    done = 1'b0;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (data_ready_o) begin
        done = 1'b1;
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
        waited++;
        if (waited > 20) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", waited);
          done = 1'b1;
        end
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int f, input bit push, input bit gaps);
    if (push) sb.push_back(exp_tab[f]);
    for (int i = 0; i < 10; i++) drive(frm[f][i], gaps);
    chk("valid_after_final", int'(result_valid_o), 1);
  endtask

  initial begin
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    data_i = '0;
    result_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(result_valid_o), 0);
    chk("rst_min1", int'(min1_o), 0);
    chk("rst_min2", int'(min2_o), 0);
    chk("rst_idx", int'(index_min1_o), 0);
    chk("rst_ready", int'(data_ready_o), 1);
    rst_i = 1'b0;

    // Directed frames, consumer always ready.
    send_frame(0, 1'b1, 1'b0);
    send_frame(1, 1'b1, 1'b0);
    send_frame(2, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Backpressure: frame 1 result held while frame 2 streams; its last element stalls.
    result_ready_i = 1'b0;
    send_frame(0, 1'b1, 1'b0);
    sb.push_back(exp_tab[1]);
    for (int i = 0; i < 9; i++) drive(frm[1][i], 1'b0);
    data_i = 4'd9;
    data_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", int'(data_ready_o), 0);
    end
    @(posedge clk); #1;
    result_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_on_take", int'(data_ready_o), 1);
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    chk("valid_stays", int'(result_valid_o), 1);
    chk("new_min1_loaded", int'(min1_o), 4);
    @(posedge clk); #1;

    // Random valid gaps.
    send_frame(3, 1'b1, 1'b1);
    send_frame(4, 1'b1, 1'b1);
    send_frame(5, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Reset with a pending result and a partial frame.
    result_ready_i = 1'b0;
    send_frame(2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(frm[0][i], 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("mid_rst_valid", int'(result_valid_o), 0);
    chk("mid_rst_min1", int'(min1_o), 0);
    chk("mid_rst_min2", int'(min2_o), 0);
    chk("mid_rst_idx", int'(index_min1_o), 0);
    chk("mid_rst_ready", int'(data_ready_o), 1);
    result_ready_i = 1'b1;
    send_frame(0, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
